// File: rtl/mult_sequencer.sv
// Purpose: execute-stage sequencer for MUL/MLA, UMULL/SMULL and UMLAL/SMLAL multiplier operations.
// Latency: result at cycle MUL_WAIT after start; long ops add one or two more word cycles.
// Backpressure: StallE freezes the sequence and masks its strobes; FlushE or reset aborts it.
module mult_sequencer #(
  parameter int MUL_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MultStartE,
  input  logic [2:0] MultControlE,
  input  logic       SetFlagsE,
  input  logic       StallE,
  input  logic       FlushE,
  output logic       MultEnable,
  output logic       WriteMultLoE,
  output logic       MultStallE,
  output logic       MultResultValidE,
  output logic       MultDestHiE,
  output logic       MultFlagWriteE,
  output logic       MultBusyE
);

  typedef enum logic [2:0] {IDLE, WAIT, CAPT, ACC_LO, HI} state_t;

  state_t     state, nxt;
  logic [3:0] waitcnt, waitcnt_nxt;
  logic       long_q, acc_q, sf_q;
  logic       c_long, c_acc, c_sf;
  logic       start, capt_now, kill;
  logic       en, wml, vld, hi, flg, stl;

  // The sign bit only affects the datapath, not the sequencing.
  logic unused_sign;
  assign unused_sign = MultControlE[1];

  assign start = (state == IDLE) & MultStartE & ~StallE & ~FlushE;
  assign kill  = ~reset | FlushE;

  // Control comes straight from the instruction in its start cycle, from the latch afterwards.
  assign c_long = (state == IDLE) ? MultControlE[2] : long_q;
  assign c_acc  = (state == IDLE) ? MultControlE[0] : acc_q;
  assign c_sf   = (state == IDLE) ? SetFlagsE       : sf_q;

  // With no wait the start cycle itself is the capture cycle.
  assign capt_now = (state == CAPT) | (start & (MUL_WAIT == 0));

  // Next-state and raw per-state strobes, before stall/flush masking.
  always_comb begin
    nxt         = state;
    waitcnt_nxt = waitcnt;
    en          = 1'b0;
    wml         = 1'b0;
    vld         = 1'b0;
    hi          = 1'b0;
    flg         = 1'b0;
    stl         = 1'b0;
    case (state)
      IDLE: begin
        if (start && (MUL_WAIT != 0)) begin
          stl = 1'b1;
          if (MUL_WAIT == 1) begin
            nxt = CAPT;
          end else begin
            nxt         = WAIT;
            waitcnt_nxt = 4'(MUL_WAIT - 1);
          end
        end
      end
      WAIT: begin
        stl = 1'b1;
        if (waitcnt <= 4'd1) begin
          nxt         = CAPT;
          waitcnt_nxt = 4'd0;
        end else begin
          waitcnt_nxt = waitcnt - 4'd1;
        end
      end
      ACC_LO: begin
        en  = 1'b1;
        vld = 1'b1;
        stl = 1'b1;
        nxt = HI;
      end
      HI: begin
        wml = ~c_acc;
        vld = 1'b1;
        hi  = 1'b1;
        flg = c_sf;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (capt_now) begin
      // Accumulating long ops capture only; the low word appears one cycle later.
      en  = 1'b1;
      vld = ~(c_long & c_acc);
      flg = ~c_long & c_sf;
      stl = c_long;
      if (!c_long)
        nxt = IDLE;
      else if (c_acc)
        nxt = ACC_LO;
      else
        nxt = HI;
    end
  end

  // State, wait counter and latched control; stall freezes, flush and reset abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      waitcnt <= 4'd0;
      long_q  <= 1'b0;
      acc_q   <= 1'b0;
      sf_q    <= 1'b0;
    end else if (FlushE) begin
      state   <= IDLE;
      waitcnt <= 4'd0;
    end else if (!StallE) begin
      state   <= nxt;
      waitcnt <= waitcnt_nxt;
      if (start) begin
        long_q <= MultControlE[2];
        acc_q  <= MultControlE[0];
        sf_q   <= SetFlagsE;
      end
    end
  end

  // Strobes are masked while stalled; everything drops on flush or reset.
  always_comb begin
    MultEnable       = en  & ~StallE & ~kill;
    WriteMultLoE     = wml & ~StallE & ~kill;
    MultResultValidE = vld & ~StallE & ~kill;
    MultDestHiE      = hi & vld & ~StallE & ~kill;
    MultFlagWriteE   = flg & ~StallE & ~kill;
    MultStallE       = stl & ~kill;
    MultBusyE        = (state != IDLE) & ~kill;
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Purpose: bench for mult_sequencer, two instances (no wait, three wait cycles) on shared inputs.
// Latency: outputs are checked 1ns after the falling edge on which each cycle's inputs are applied.
// Backpressure: random StallE masks plus flush/reset aborts; a cycle budget bounds each operation.
module tb_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       MultStartE = 1'b0;
  logic [2:0] MultControlE = 3'b000;
  logic       SetFlagsE = 1'b0;
  logic       StallE = 1'b0;
  logic       FlushE = 1'b0;

  logic en0, wml0, stl0, vld0, hi0, flg0, bsy0;
  logic en3, wml3, stl3, vld3, hi3, flg3, bsy3;
  logic [6:0] out0, out3;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.MUL_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .MultStartE(MultStartE), .MultControlE(MultControlE),
    .SetFlagsE(SetFlagsE), .StallE(StallE), .FlushE(FlushE),
    .MultEnable(en0), .WriteMultLoE(wml0), .MultStallE(stl0), .MultResultValidE(vld0),
    .MultDestHiE(hi0), .MultFlagWriteE(flg0), .MultBusyE(bsy0));

  mult_sequencer #(.MUL_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .MultStartE(MultStartE), .MultControlE(MultControlE),
    .SetFlagsE(SetFlagsE), .StallE(StallE), .FlushE(FlushE),
    .MultEnable(en3), .WriteMultLoE(wml3), .MultStallE(stl3), .MultResultValidE(vld3),
    .MultDestHiE(hi3), .MultFlagWriteE(flg3), .MultBusyE(bsy3));

  // Output vector order: {enable, write_lo_sel, valid, dest_hi, flag_write, stall, busy}
  assign out0 = {en0, wml0, vld0, hi0, flg0, stl0, bsy0};
  assign out3 = {en3, wml3, vld3, hi3, flg3, stl3, bsy3};

  // Number of cycles an unstalled operation occupies.
  function automatic int oplen(int w, logic lng, logic acc);
    return w + (lng ? (acc ? 3 : 2) : 1);
  endfunction

  // Expected outputs at step k of an operation, from the per-form cycle timeline.
  function automatic logic [6:0] model(int w, logic lng, logic acc, logic sf, int k, bit stalled);
    logic en, wml, v, hi, fl;
    int   j;
    en = 1'b0; wml = 1'b0; v = 1'b0; hi = 1'b0; fl = 1'b0;
    j = k - w;
    if (j >= 0) begin
      if (!lng) begin
        en = 1'b1; v = 1'b1; fl = sf;
      end else if (!acc) begin
        if (j == 0) begin
          en = 1'b1; v = 1'b1;
        end else begin
          wml = 1'b1; v = 1'b1; hi = 1'b1; fl = sf;
        end
      end else begin
        if (j == 0) begin
          en = 1'b1;
        end else if (j == 1) begin
          en = 1'b1; v = 1'b1;
        end else begin
          v = 1'b1; hi = 1'b1; fl = sf;
        end
      end
    end
    if (stalled) begin
      en = 1'b0; wml = 1'b0; v = 1'b0; hi = 1'b0; fl = 1'b0;
    end
    return {en, wml, v, hi, fl, (k != oplen(w, lng, acc) - 1), (k > 0)};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Runs one operation on both instances. smask[c] stalls cycle c (c>0);
  // killc is the cycle at which a flush (or reset if kill_rst) is applied, -1 for none.
  task automatic run_op(input string tag, input logic [2:0] ctl, input logic sf,
                        input logic [15:0] smask, input int killc, input bit kill_rst);
    int k0, k3, c, l0, l3;
    bit st, kl, done;
    logic [6:0] e0, e3;
    k0 = 0; k3 = 0; c = 0; done = 0;
    l0 = oplen(0, ctl[2], ctl[0]);
    l3 = oplen(3, ctl[2], ctl[0]);
    while (!done) begin
      st = (c > 0) && (c < 16) && smask[c];
      kl = (c == killc);
      @(negedge clk);
      MultStartE   = (c == 0);
      MultControlE = ctl;
      SetFlagsE    = sf;
      StallE       = st;
      FlushE       = kl && !kill_rst;
      reset        = !(kl && kill_rst);
      #1;
      e0 = (kl || k0 >= l0) ? 7'd0 : model(0, ctl[2], ctl[0], sf, k0, st);
      e3 = (kl || k3 >= l3) ? 7'd0 : model(3, ctl[2], ctl[0], sf, k3, st);
      check({tag, "/w0"}, out0, e0);
      check({tag, "/w3"}, out3, e3);
      if (!st) begin
        k0++;
        k3++;
      end
      c++;
      done = kl || (k0 >= l0 && k3 >= l3) || (c > 60);
    end
    if (c > 60) begin
      cmp++;
      bad++;
      $error("FAIL %s timeout observed=%0d cycles expected<=60", tag, c);
    end
  endtask

  initial begin
    logic [2:0]  ctl;
    logic [15:0] sm;
    int          kc;

    // Reset held low: everything zero even with a start presented.
    repeat (2) begin
      @(negedge clk);
      reset = 1'b0; MultStartE = 1'b1; MultControlE = 3'b101; SetFlagsE = 1'b1;
      #1;
      check("reset/w0", out0, 7'd0);
      check("reset/w3", out3, 7'd0);
    end
    @(negedge clk);
    reset = 1'b1; MultStartE = 1'b0;
    #1;
    check("idle/w0", out0, 7'd0);
    check("idle/w3", out3, 7'd0);

    // Directed forms.
    run_op("mul_s",   3'b000, 1'b1, 16'h0000, -1, 0);
    run_op("mla",     3'b001, 1'b0, 16'h0000, -1, 0);
    run_op("umull",   3'b100, 1'b1, 16'h0000, -1, 0);
    run_op("umlal",   3'b101, 1'b1, 16'h0000, -1, 0);
    run_op("smull",   3'b110, 1'b0, 16'h0000, -1, 0);
    run_op("smlal_st",3'b111, 1'b1, 16'h0006, -1, 0);
    run_op("umull_fl",3'b100, 1'b1, 16'h0000,  1, 0);
    run_op("mul_aft", 3'b000, 1'b1, 16'h0000, -1, 0);
    run_op("umull_rs",3'b100, 1'b1, 16'h0000,  1, 1);
    run_op("mul_aft2",3'b000, 1'b0, 16'h0000, -1, 0);
    run_op("stl_wait",3'b110, 1'b1, 16'h0024, -1, 0);
    run_op("fl_wait", 3'b111, 1'b1, 16'h0000,  2, 0);
    run_op("fl_stall",3'b101, 1'b1, 16'h0002,  1, 0);

    // Random operations back to back.
    for (int i = 0; i < 60; i++) begin
      ctl = 3'($urandom_range(0, 7));
      sm  = 16'($urandom & $urandom);
      kc  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_op("rnd", ctl, 1'($urandom), sm, kc, 1'($urandom));
    end

    @(negedge clk);
    MultStartE = 1'b0; StallE = 1'b0; FlushE = 1'b0; reset = 1'b1;
    #1;
    check("end/w0", out0, 7'd0);
    check("end/w3", out3, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
